// File: rtl/card_shoe_pkg.sv
// ============================================================================
// Module      : card_shoe_pkg
// Description : Shared deck constants, state encoding and index helper for the
//               card shoe and its decode logic.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package card_shoe_pkg;

    localparam int DECK_CARDS = 52;
    localparam int RANKS      = 13;
    localparam int FACE_VALUE = 10;

    localparam int IDX_W   = 6;
    localparam int VALUE_W = 5;
    localparam int RANK_W  = 4;
    localparam int SUIT_W  = 2;
    localparam int LEFT_W  = 6;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SCAN    = 2'd1,
        ST_DELIVER = 2'd2
    } shoe_state_e;

    // Deck index successor; wraps at the last card so 52..63 never appear.
    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] idx);
        return (idx == IDX_W'(DECK_CARDS - 1)) ? '0 : idx + 1'b1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/card_shoe_index_decode.sv
// ============================================================================
// Module      : shoe_index_decode
// Description : Combinational deck index to rank / suit / blackjack value.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module shoe_index_decode
    import card_shoe_pkg::*;
(
    input  logic [IDX_W-1:0]   index_i,
    output logic [RANK_W-1:0]  rank_o,
    output logic [SUIT_W-1:0]  suit_o,
    output logic [VALUE_W-1:0] value_o
);

    logic [IDX_W-1:0]  rem;
    logic [RANK_W-1:0] rank;

    // Division by 13 resolved as a compare chain against the suit boundaries.
    always_comb begin
        suit_o = '0;
        rem    = index_i;
        if (index_i >= IDX_W'(3 * RANKS)) begin
            suit_o = 2'd3;
            rem    = index_i - IDX_W'(3 * RANKS);
        end else if (index_i >= IDX_W'(2 * RANKS)) begin
            suit_o = 2'd2;
            rem    = index_i - IDX_W'(2 * RANKS);
        end else if (index_i >= IDX_W'(RANKS)) begin
            suit_o = 2'd1;
            rem    = index_i - IDX_W'(RANKS);
        end
        rank    = RANK_W'(rem + 6'd1);
        rank_o  = rank;
        value_o = (rank > 4'd10) ? VALUE_W'(FACE_VALUE) : {1'b0, rank};
    end

endmodule

`default_nettype wire

// File: rtl/card_shoe.sv
// ============================================================================
// Module      : card_shoe
// Description : Single-deck card shoe answering draw requests with one undealt
//               card, scanning the dealt bitmap from a free-running pointer.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module card_shoe
    import card_shoe_pkg::*;
(
    input  logic               Clock,
    input  logic               reset_n,
    input  logic               draw_req,
    input  logic               shuffle,
    output logic               card_valid,
    output logic [VALUE_W-1:0] card_value,
    output logic [RANK_W-1:0]  card_rank,
    output logic [SUIT_W-1:0]  card_suit,
    output logic               busy,
    output logic               empty,
    output logic [LEFT_W-1:0]  cards_left,
    output logic               draw_err
);

    shoe_state_e               state_q, state_d;
    logic [DECK_CARDS-1:0]     dealt_q, dealt_d;
    logic [IDX_W-1:0]          rand_ptr_q;
    logic [IDX_W-1:0]          scan_idx_q, scan_idx_d;
    logic [LEFT_W-1:0]         cards_left_q, cards_left_d;
    logic [RANK_W-1:0]         rank_q, rank_d;
    logic [SUIT_W-1:0]         suit_q, suit_d;
    logic [VALUE_W-1:0]        value_q, value_d;
    logic                      draw_err_q, draw_err_d;

    logic [RANK_W-1:0]         dec_rank;
    logic [SUIT_W-1:0]         dec_suit;
    logic [VALUE_W-1:0]        dec_value;

    shoe_index_decode u_decode (
        .index_i (scan_idx_q),
        .rank_o  (dec_rank),
        .suit_o  (dec_suit),
        .value_o (dec_value)
    );

    always_comb begin
        state_d      = state_q;
        dealt_d      = dealt_q;
        scan_idx_d   = scan_idx_q;
        cards_left_d = cards_left_q;
        rank_d       = rank_q;
        suit_d       = suit_q;
        value_d      = value_q;
        draw_err_d   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (draw_req && !shuffle) begin
                    if (cards_left_q == '0) begin
                        draw_err_d = 1'b1;
                    end else begin
                        scan_idx_d = rand_ptr_q;
                        state_d    = ST_SCAN;
                    end
                end
            end
            ST_SCAN: begin
                if (!dealt_q[scan_idx_q]) begin
                    dealt_d[scan_idx_q] = 1'b1;
                    rank_d              = dec_rank;
                    suit_d              = dec_suit;
                    value_d             = dec_value;
                    cards_left_d        = cards_left_q - 6'd1;
                    state_d             = ST_DELIVER;
                end else begin
                    scan_idx_d = next_idx(scan_idx_q);
                end
            end
            ST_DELIVER: state_d = ST_IDLE;
            default:    state_d = ST_IDLE;
        endcase

        // Shuffle returns every card, including one being delivered this cycle.
        if (shuffle) begin
            dealt_d      = '0;
            cards_left_d = LEFT_W'(DECK_CARDS);
            state_d      = ST_IDLE;
        end
    end

    always_ff @(posedge Clock) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            dealt_q      <= '0;
            rand_ptr_q   <= '0;
            scan_idx_q   <= '0;
            cards_left_q <= LEFT_W'(DECK_CARDS);
            rank_q       <= '0;
            suit_q       <= '0;
            value_q      <= '0;
            draw_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            dealt_q      <= dealt_d;
            rand_ptr_q   <= next_idx(rand_ptr_q);
            scan_idx_q   <= scan_idx_d;
            cards_left_q <= cards_left_d;
            rank_q       <= rank_d;
            suit_q       <= suit_d;
            value_q      <= value_d;
            draw_err_q   <= draw_err_d;
        end
    end

    assign card_valid = (state_q == ST_DELIVER);
    assign busy       = (state_q != ST_IDLE);
    assign empty      = (cards_left_q == '0);
    assign cards_left = cards_left_q;
    assign card_rank  = rank_q;
    assign card_suit  = suit_q;
    assign card_value = value_q;
    assign draw_err   = draw_err_q;

endmodule

`default_nettype wire

// File: tb/tb_card_shoe.sv
// ============================================================================
// Module      : tb_card_shoe
// Description : Directed self-checking bench for the card shoe.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_card_shoe;

    logic       Clock = 1'b0;
    logic       reset_n = 1'b0;
    logic       draw_req = 1'b0;
    logic       shuffle = 1'b0;
    logic       card_valid;
    logic [4:0] card_value;
    logic [3:0] card_rank;
    logic [1:0] card_suit;
    logic       busy;
    logic       empty;
    logic [5:0] cards_left;
    logic       draw_err;

    int tests = 0;
    int fails = 0;
    logic [5:0] mptr = '0;

    card_shoe dut (
        .Clock      (Clock),
        .reset_n    (reset_n),
        .draw_req   (draw_req),
        .shuffle    (shuffle),
        .card_valid (card_valid),
        .card_value (card_value),
        .card_rank  (card_rank),
        .card_suit  (card_suit),
        .busy       (busy),
        .empty      (empty),
        .cards_left (cards_left),
        .draw_err   (draw_err)
    );

    always #5 Clock = ~Clock;

    // Expected rand_ptr: counts cycles since reset, modulo the deck size.
    always @(posedge Clock) begin
        if (!reset_n)         mptr <= '0;
        else if (mptr == 51)  mptr <= '0;
        else                  mptr <= mptr + 6'd1;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        int ptr;
        int k;
        int rank;
        int suit;
        int value;
        int left;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Called at a negedge; pulses draw_req for the edge where rand_ptr == p (p<0: now).
    task automatic issue(input int p);
        if (p >= 0) begin
            for (int i = 0; i < 60 && int'(mptr) != p; i++) @(negedge Clock);
        end
        draw_req = 1'b1;
        @(negedge Clock);
        draw_req = 1'b0;
    endtask

    // Leaves the caller at the negedge where card_valid is high.
    task automatic wait_card(output int idx, output int cyc, output bit ok);
        cyc = 0;
        ok  = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (card_valid) begin
                ok = 1'b1;
                break;
            end
            @(negedge Clock);
            cyc++;
        end
        idx = int'(card_suit) * 13 + int'(card_rank) - 1;
        chk("card_valid_timeout", {31'd0, ok}, 32'd1);
    endtask

    vec_t vecs[11];
    int   idx, cyc;
    bit   ok;
    bit   any_cv;
    logic [51:0] seen;

    initial begin
        vecs[0]  = '{ptr: 0,  k: 0, rank: 1,  suit: 0, value: 1,  left: 51};
        vecs[1]  = '{ptr: 0,  k: 1, rank: 2,  suit: 0, value: 2,  left: 50};
        vecs[2]  = '{ptr: 12, k: 0, rank: 13, suit: 0, value: 10, left: 49};
        vecs[3]  = '{ptr: 51, k: 0, rank: 13, suit: 3, value: 10, left: 48};
        vecs[4]  = '{ptr: 51, k: 3, rank: 3,  suit: 0, value: 3,  left: 47};
        vecs[5]  = '{ptr: 25, k: 0, rank: 13, suit: 1, value: 10, left: 46};
        vecs[6]  = '{ptr: 26, k: 0, rank: 1,  suit: 2, value: 1,  left: 45};
        vecs[7]  = '{ptr: 38, k: 0, rank: 13, suit: 2, value: 10, left: 44};
        vecs[8]  = '{ptr: 39, k: 0, rank: 1,  suit: 3, value: 1,  left: 43};
        vecs[9]  = '{ptr: 48, k: 0, rank: 10, suit: 3, value: 10, left: 42};
        vecs[10] = '{ptr: 49, k: 0, rank: 11, suit: 3, value: 10, left: 41};

        repeat (3) @(negedge Clock);
        chk("rst_card_valid", {31'd0, card_valid}, 32'd0);
        chk("rst_busy",       {31'd0, busy},       32'd0);
        chk("rst_empty",      {31'd0, empty},      32'd0);
        chk("rst_draw_err",   {31'd0, draw_err},   32'd0);
        chk("rst_cards_left", {26'd0, cards_left}, 32'd52);
        chk("rst_card",       {21'd0, card_value, card_rank, card_suit}, 32'd0);
        reset_n = 1'b1;

        foreach (vecs[i]) begin
            issue(vecs[i].ptr);
            wait_card(idx, cyc, ok);
            chk($sformatf("v%0d_latency", i), cyc,          1 + vecs[i].k);
            chk($sformatf("v%0d_rank", i),    card_rank,    vecs[i].rank);
            chk($sformatf("v%0d_suit", i),    card_suit,    vecs[i].suit);
            chk($sformatf("v%0d_value", i),   card_value,   vecs[i].value);
            chk($sformatf("v%0d_left", i),    cards_left,   vecs[i].left);
            chk($sformatf("v%0d_empty", i),   empty,        0);
            @(negedge Clock);
        end

        // Reset mid-scan with draw_req held through it.
        issue(48);
        chk("midscan_busy", busy, 1);
        reset_n  = 1'b0;
        draw_req = 1'b1;
        @(negedge Clock);
        chk("mrst_card_valid", card_valid, 0);
        chk("mrst_busy",       busy,       0);
        chk("mrst_cards_left", cards_left, 52);
        chk("mrst_card",       {card_value, card_rank, card_suit}, 0);
        @(negedge Clock);
        reset_n = 1'b1;
        @(negedge Clock);
        chk("post_rst_busy", busy, 1);
        draw_req = 1'b0;
        wait_card(idx, cyc, ok);
        chk("post_rst_latency", cyc, 1);
        chk("post_rst_idx",     idx, 0);
        chk("post_rst_left",    cards_left, 51);
        @(negedge Clock);

        // Drain the deck: every index exactly once.
        seen = 52'd1;
        for (int n = 0; n < 51; n++) begin
            issue(-1);
            wait_card(idx, cyc, ok);
            if (ok) begin
                chk($sformatf("drain%0d_dup", n), seen[idx], 0);
                seen[idx] = 1'b1;
            end
            chk($sformatf("drain%0d_left", n),  cards_left, 50 - n);
            chk($sformatf("drain%0d_empty", n), empty, (n == 50) ? 1 : 0);
            @(negedge Clock);
        end
        chk("drain_all_seen", {31'd0, &seen}, 32'd1);

        // Draw from an empty shoe.
        issue(-1);
        chk("err_pulse", draw_err, 1);
        chk("err_busy",  busy,     0);
        any_cv = 1'b0;
        @(negedge Clock);
        chk("err_one_cycle", draw_err, 0);
        for (int i = 0; i < 5; i++) begin
            any_cv |= card_valid | busy;
            @(negedge Clock);
        end
        chk("err_no_card", any_cv, 0);

        shuffle = 1'b1;
        @(negedge Clock);
        shuffle = 1'b0;
        chk("shuf_left",  cards_left, 52);
        chk("shuf_empty", empty,      0);

        // From ptr 0, the i-th draw on a fresh deck yields index i after i probes.
        for (int i = 0; i < 40; i++) begin
            issue(0);
            wait_card(idx, cyc, ok);
            chk($sformatf("seq%0d_idx", i), idx, i);
            chk($sformatf("seq%0d_lat", i), cyc, 1 + i);
            @(negedge Clock);
        end

        issue(0);
        repeat (5) @(negedge Clock);
        chk("long_scan_busy", busy, 1);
        shuffle = 1'b1;
        @(negedge Clock);
        shuffle = 1'b0;
        chk("abort_left",  cards_left, 52);
        chk("abort_empty", empty,      0);
        chk("abort_busy",  busy,       0);
        chk("abort_hold",  {card_rank, card_suit}, {4'd1, 2'd3});
        any_cv = 1'b0;
        for (int i = 0; i < 50; i++) begin
            any_cv |= card_valid;
            @(negedge Clock);
        end
        chk("abort_no_card", any_cv, 0);

        // Simultaneous shuffle and draw_req: request dropped.
        draw_req = 1'b1;
        shuffle  = 1'b1;
        @(negedge Clock);
        draw_req = 1'b0;
        shuffle  = 1'b0;
        chk("simul_busy", busy, 0);
        any_cv = 1'b0;
        for (int i = 0; i < 5; i++) begin
            any_cv |= card_valid | busy;
            @(negedge Clock);
        end
        chk("simul_no_card", any_cv, 0);
        chk("simul_left", cards_left, 52);

        // Shuffle during DELIVER: card still delivered, then returned.
        issue(5);
        wait_card(idx, cyc, ok);
        chk("dlv_rank", card_rank,  6);
        chk("dlv_left", cards_left, 51);
        shuffle = 1'b1;
        @(negedge Clock);
        shuffle = 1'b0;
        chk("dlv_shuf_cv",   card_valid, 0);
        chk("dlv_shuf_left", cards_left, 52);
        chk("dlv_shuf_hold", card_rank,  6);
        issue(5);
        wait_card(idx, cyc, ok);
        chk("returned_idx", idx, 5);
        chk("returned_lat", cyc, 1);
        @(negedge Clock);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

`default_nettype wire
